clkdiv_prog: RTL
================

Name: clkdiv_prog

Overview:
Programmable clock-enable/clock divider for the Z80 system clock, replacing the fixed-ratio divider. Produces a 50%-duty divided clock and a one-cycle tick strobe at the divided rate. The half-period is loadable at run time and changes without glitches. A single-step mode emits exactly one full output period per request, for CPU debug. Sits between the board oscillator and the CPU/peripheral clock-enable fabric.

Parameters:
CNT_W, 20, width of the half-period counter and divisor register
DEFAULT_DIV, 500000, reset value of the half-period divisor, in input cycles; must fit in CNT_W
BYPASS, 0, when 1, clk_out = clk_in combinationally, tick = 1, and all other logic is unused (simulation speed-up)

Ports:
clk_in  input  1  system clock; all logic is on its rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  run enable; when low, the counter and outputs freeze
step_mode  input  1  0 = free-run, 1 = single-step
step  input  1  single-step request; acts on the rising edge detected inside the block
div_load  input  1  one-cycle strobe that captures div_val
div_val  input  CNT_W  new half-period, in clk_in cycles
clk_out  output  1  divided clock
tick  output  1  one-cycle pulse on each clk_out 0->1 transition
step_busy  output  1  high while a single-step period is in progress

Behaviour:
- Reset (async assert, release synchronous to clk_in):
  - cnt = 0, clk_out = 0, tick = 0, step_busy = 0
  - div_reg = DEFAULT_DIV, div_pend = 0, pend_flag = 0, step_q = 0
- Effective half-period H = max(div_reg, 1); div_val = 0 is treated as 1.
- Counter advances only when active:
  - active = en AND (NOT step_mode OR step_busy)
  - When active: if cnt == H-1, then cnt <= 0 and clk_out toggles (terminal count); otherwise cnt <= cnt+1.
- Free-run output period = 2*H clk_in cycles at exact 50% duty. First 0->1 transition after reset is H cycles after en is first sampled high.
- tick is registered. It is 1 in the cycle where clk_out becomes 1, and 0 at all other times, including while inactive.
- Divisor load:
  - On div_load: div_pend <= div_val, pend_flag <= 1.
  - While active, the pending value transfers to div_reg only at a terminal count where clk_out goes 1->0 (period boundary); pend_flag then clears. No shortened or stretched half-period is ever produced.
  - When not active, the transfer happens on the next cycle and cnt resets to 0.
  - Back-to-back loads: the latest value wins.
  - A load coinciding with a transfer: the new value stays pending.
- en low: cnt and clk_out hold their values, tick = 0. Pending loads are still accepted and applied per the inactive rule.
- Single-step FSM, states IDLE and RUN:
  - IDLE -> RUN on (step AND NOT step_q AND step_mode AND en AND clk_out == 0). step_busy <= 1, cnt <= 0.
  - RUN: normal counting. clk_out is high for H cycles, then low. RUN -> IDLE on the terminal count that drives clk_out 1->0; step_busy <= 0.
  - step edges during RUN are ignored (not queued).
  - If step_mode goes 1 while clk_out = 1, free-run continues until clk_out falls, then the block holds low.
  - If step_mode goes 0 during RUN, the block finishes as free-run with no discontinuity.
- step_q is step delayed one cycle. Edge detection only; synchronising step is the caller's job.
- Reset mid-operation forces all reset values immediately, including during RUN and with a load pending.

Test Plan:
1. DEFAULT_DIV = 3, en = 1 from reset -> clk_out period 6 cycles (3 high, 3 low); tick is exactly one cycle wide, every 6 cycles; first rise 3 cycles after en.
2. Free-run H = 4, div_load with div_val = 2 mid high phase -> the current period completes at 4/4; the next period is 2/2; no runt pulse.
3. div_val = 0 loaded -> H = 1; clk_out toggles every cycle; tick on every other cycle.
4. step_mode = 1, H = 5, step pulse -> clk_out high 5 cycles, low; step_busy high 10 cycles; a second step edge during busy produces no extra period.
5. en dropped for 7 cycles mid low phase -> cnt and clk_out frozen, tick = 0; resumes with the remaining count intact.
6. rst_n asserted mid RUN with a load pending -> outputs 0 asynchronously; after release, H = DEFAULT_DIV and pend_flag = 0.

Source files
------------

// File: rtl/clkdiv_prog.sv
// Programmable 50%-duty clock divider with tick strobe, glitch-free divisor reload
// and a single-step mode that emits exactly one output period per request.
module clkdiv_prog #(
    parameter int CNT_W       = 20,
    parameter int DEFAULT_DIV = 500000,
    parameter bit BYPASS      = 1'b0
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             step_mode,
    input  logic             step,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    output logic             clk_out,
    output logic             tick,
    output logic             step_busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] pend_val_q;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;
    logic             step_q;

    logic [CNT_W-1:0] h_m1;
    logic             busy;
    logic             active;
    logic             term;
    logic             start;

    // A stored divisor of zero behaves as one, so the terminal count is never below zero.
    assign h_m1   = (div_q == '0) ? '0 : div_q - CNT_W'(1);
    assign busy   = (state_q == S_RUN);
    // A high half-period always completes, even if single-step is requested mid-phase.
    assign active = en & (~step_mode | busy | clk_q);
    assign term   = active & (cnt_q == h_m1);
    assign start  = (state_q == S_IDLE) & step & ~step_q & step_mode & en & ~clk_q;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= CNT_W'(DEFAULT_DIV);
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            step_q <= step;
            tick_q <= term & ~clk_q;

            if (active) begin
                if (term) begin
                    cnt_q <= '0;
                    clk_q <= ~clk_q;
                    // Falling edge closes a period: the only safe point to swap divisors.
                    if (clk_q) begin
                        if (pend_q) begin
                            div_q  <= pend_val_q;
                            pend_q <= 1'b0;
                        end
                        if (state_q == S_RUN) begin
                            state_q <= S_IDLE;
                        end
                    end
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                if (pend_q) begin
                    div_q  <= pend_val_q;
                    pend_q <= 1'b0;
                    cnt_q  <= '0;
                end
                if (start) begin
                    state_q <= S_RUN;
                    cnt_q   <= '0;
                end
            end

            // A fresh load overrides any transfer-clear above and stays pending.
            if (div_load) begin
                pend_val_q <= div_val;
                pend_q     <= 1'b1;
            end
        end
    end

    generate
        if (BYPASS) begin : g_bypass
            assign clk_out   = clk_in;
            assign tick      = 1'b1;
            assign step_busy = 1'b0;
        end else begin : g_div
            assign clk_out   = clk_q;
            assign tick      = tick_q;
            assign step_busy = busy;
        end
    endgenerate

endmodule
